// File: rtl/alu_pkg.sv
// Shared types and the combinational ALU evaluation used by the request/response front end.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SLT = 3'b101
  } alu_op_e;

  typedef struct packed {
    logic [3:0] out;
    logic       carry;
    logic       err;
  } alu_rsp_t;

  function automatic alu_rsp_t alu_eval(input logic [3:0] a, input logic [3:0] b,
                                        input logic [2:0] sel);
    alu_rsp_t   r;
    logic [4:0] wide;
    r    = '0;
    wide = '0;
    case (sel)
      OP_ADD: begin
        wide    = {1'b0, a} + {1'b0, b};
        r.out   = wide[3:0];
        r.carry = wide[4];
      end
      OP_SUB: begin
        // Bit 4 of the 5-bit difference is the unsigned borrow.
        wide    = {1'b0, a} - {1'b0, b};
        r.out   = wide[3:0];
        r.carry = wide[4];
      end
      OP_AND:  r.out = a & b;
      OP_OR:   r.out = a | b;
      OP_XOR:  r.out = a ^ b;
      OP_SLT:  r.out = {3'b000, ($signed(a) < $signed(b))};
      default: r.err = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_rsp_fifo.sv
// In-order response buffer; the read port holds the last popped entry while empty.
module alu_rsp_fifo
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push_i,
  input  alu_rsp_t        wdata_i,
  input  logic            pop_i,
  output alu_rsp_t        rdata_o,
  output logic [CntW-1:0] count_o
);

  alu_rsp_t            mem_q [DEPTH];
  alu_rsp_t            last_q, last_d;
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]     count_q, count_d;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    last_d   = last_q;
    count_d  = count_q + CntW'(push_i) - CntW'(pop_i);
    if (pop_i) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
      last_d   = mem_q[rd_ptr_q];
    end
    if (push_i) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      // When full with a same-cycle pop, wr_ptr equals rd_ptr: the popped slot is reused.
      if (push_i) begin
        mem_q[wr_ptr_q] <= wdata_i;
      end
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      last_q   <= last_d;
    end
  end

  assign rdata_o = (count_q != '0) ? mem_q[rd_ptr_q] : last_q;
  assign count_o = count_q;

endmodule

// File: rtl/alu_req_responder.sv
// Valid/ready front end for the 4-bit ALU: evaluates each accepted request and returns it in order.
module alu_req_responder
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 8,
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_a,
  input  logic [3:0]       req_b,
  input  logic [2:0]       req_sel,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [3:0]       rsp_out,
  output logic             rsp_carry,
  output logic             rsp_err,
  output logic [CNT_W-1:0] req_count
);

  logic [CntW-1:0]  fifo_count;
  alu_rsp_t         head;
  logic             accept;
  logic             pop;
  logic [CNT_W-1:0] req_count_q, req_count_d;

  assign rsp_valid = (fifo_count != '0);
  assign pop       = rsp_valid & rsp_ready;
  assign req_ready = (fifo_count != CntW'(DEPTH)) | pop;
  assign accept    = req_valid & req_ready;

  alu_rsp_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (accept),
    .wdata_i(alu_eval(req_a, req_b, req_sel)),
    .pop_i  (pop),
    .rdata_o(head),
    .count_o(fifo_count)
  );

  always_comb begin
    req_count_d = req_count_q;
    if (accept) begin
      req_count_d = req_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_count_q <= '0;
    end else begin
      req_count_q <= req_count_d;
    end
  end

  assign rsp_out   = head.out;
  assign rsp_carry = head.carry;
  assign rsp_err   = head.err;
  assign req_count = req_count_q;

endmodule
